data_mem_hs: RTL and testbench

- Parametrised, byte-addressed, byte-enabled data memory with valid/ready request and response channels.
- Successor to the core's combinational-read data memory.
- Adds registered reads, a buffered response path with backpressure, alignment and range error reporting, and a hardware zero-initialisation sweep.
- Sits between the load/store unit (or DMA) and on-chip SRAM.

---
 rtl/data_mem_pkg.sv | 38 +++
 rtl/rsp_fifo.sv | 81 ++++++++
 rtl/data_mem_hs.sv | 193 +++++++++++++++++++
 tb/tb_data_mem_hs.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared definitions for the handshaked data memory:
//               FSM state encoding, response entry flag fields and helpers
//               that derive the address-offset and index widths.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

  // Controller state: zero sweep, then normal operation
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Status part of a response entry; the data-width-dependent rdata field is
  // prepended by the user, since package types cannot be parametrised.
  typedef struct packed {
    logic err;
    logic we;
  } rsp_flags_t;

  // Number of byte-offset bits inside one word
  function automatic int unsigned calc_offs(input int unsigned data_width);
    if (data_width <= 8) return 0;
    return $clog2(data_width / 8);
  endfunction

  // Index width that stays legal for a depth of 1
  function automatic int unsigned idx_width(input int unsigned depth);
    if (depth <= 1) return 1;
    return $clog2(depth);
  endfunction

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rsp_fifo
// Description : Small synchronous FIFO for response buffering. Pointers wrap
//               modulo DEPTH, so any DEPTH >= 1 is supported. A push while
//               full is accepted only together with a pop.
// Ports       : clk, rst (async, active-high)
//               push_i, pop_i, wdata_i[WIDTH]  -> write / read strobes, data
//               rdata_o[WIDTH]                 <- head entry
//               full_o, empty_o, count_o       <- occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module rsp_fifo
  import data_mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o  = (count_q == c_depth);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
    if (w_do_pop)  rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only visible when counted
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : rsp_fifo
`default_nettype wire

// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_hs
// Description : Byte-addressed, byte-enabled data memory with valid/ready
//               request and response channels, registered reads, buffered
//               responses with backpressure, alignment/range error reporting
//               and a hardware zero-initialisation sweep after reset.
//               Optional macro DATA_MEM_PRELOAD_EN: skip the sweep; RUN is
//               entered one edge after reset release.
// Ports       : clk, rst (async, active-high)
//               req_valid/req_ready/req_we/req_addr/req_wdata/req_be : request
//               rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_we        : response
//               init_done : memory usable
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_hs
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1 << (ADDR_WIDTH - $clog2(DATA_WIDTH / 8)),
  parameter int RSP_DEPTH  = 2,
  parameter     INIT_FILE  = "../../data/dataMem_h.mem"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_we,
  output logic                    init_done
);

  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int OFFS    = calc_offs(DATA_WIDTH);
  localparam int IDX_W   = idx_width(MEM_DEPTH);
  localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
  localparam int ENTRY_W = DATA_WIDTH + $bits(rsp_flags_t);

  localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   c_depth    = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]      c_rsp_dep  = CNT_W'(RSP_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    rsp_flags_t            flags;
  } rsp_entry_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      init_cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  w_run;
  logic                  w_init_we;

  // --------------------------------------------------------------------------
  // Address decode and error check
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic [IDX_W-1:0]      w_mem_idx;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_err;

  assign w_word_idx     = req_addr >> OFFS;
  assign w_mem_idx      = w_word_idx[IDX_W-1:0];
  assign w_out_of_range = ({1'b0, w_word_idx} >= c_depth);

  generate
    if (OFFS > 0) begin : g_align_check
      assign w_misaligned = |req_addr[OFFS-1:0];
    end else begin : g_no_align_check
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign w_err = w_misaligned || w_out_of_range;

  // --------------------------------------------------------------------------
  // Handshake and response buffer
  // --------------------------------------------------------------------------
  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic             w_has_space;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_rsp_count;
  rsp_entry_t       w_push_entry;
  rsp_entry_t       w_head;
  logic [ENTRY_W-1:0] w_head_bits;

  assign w_pop       = rsp_valid && rsp_ready;
  // A full buffer still accepts when the head leaves this same cycle, so
  // req_ready deliberately depends combinationally on rsp_ready.
  assign w_has_space = (w_rsp_count < c_rsp_dep) || w_pop;
  assign req_ready   = w_run && w_has_space;
  assign w_accept    = req_valid && req_ready;
  // The full term is redundant with req_ready; it keeps the buffer safe
  // should the acceptance logic ever be altered.
  assign w_push      = w_accept && (!w_fifo_full || w_pop);

  // Reads sample the array at the acceptance edge; the FIFO entry itself is
  // the read register, giving one cycle of latency into an empty buffer.
  always_comb begin
    w_push_entry           = '0;
    w_push_entry.flags.err = w_err;
    w_push_entry.flags.we  = req_we;
    if (!req_we && !w_err) w_push_entry.rdata = mem_q[w_mem_idx];
  end

  rsp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_push_entry),
    .rdata_o (w_head_bits),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_rsp_count)
  );

  assign w_head    = rsp_entry_t'(w_head_bits);
  assign rsp_valid = !w_fifo_empty;
  assign rsp_rdata = rsp_valid ? w_head.rdata     : '0;
  assign rsp_err   = rsp_valid ? w_head.flags.err : 1'b0;
  assign rsp_we    = rsp_valid ? w_head.flags.we  : 1'b0;

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef DATA_MEM_PRELOAD_EN
      ST_INIT: state_d = ST_RUN;
`else
      ST_INIT: if (init_cnt_q == c_last_idx) state_d = ST_RUN;
`endif
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    w_run     = (state_q == ST_RUN);
    init_done = w_run;
`ifdef DATA_MEM_PRELOAD_EN
    w_init_we = 1'b0;
`else
    w_init_we = (state_q == ST_INIT);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            init_cnt_q <= '0;
    else if (w_init_we) init_cnt_q <= init_cnt_q + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Storage array (never reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      mem_q[init_cnt_q] <= '0;
    end else if (w_accept && req_we && !w_err) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem_q[w_mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule : data_mem_hs
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_hs
// Description : Directed self-checking bench for data_mem_hs with
//               DATA_WIDTH=32, MEM_DEPTH=16, RSP_DEPTH=2. Outputs are sampled
//               on the falling edge or 1 time unit after an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_hs;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MD = 16;
  localparam int RD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_we;
  logic          init_done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] stream_data [8];

  always #5 clk = ~clk;

  data_mem_hs #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (MD),
    .RSP_DEPTH  (RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_we    (rsp_we),
    .init_done (init_done)
  );

  // Drive one request and hold it until accepted (bounded); returns 1 time
  // unit after the accepting edge with the request withdrawn.
  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [3:0] be);
    int waited = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    #1;
    while (!req_ready && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    n_cmp++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL issue_timeout addr=%h: req_ready=%b, required 1", addr, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
  endtask

  task automatic test_reset();
    logic [37:0] got;
    #12;
    got = {req_ready, rsp_valid, init_done, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required %h", got, 38'h0);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= MD; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({init_done, req_ready} !== {2{k == MD}}) begin
        n_fail++;
        $display("FAIL init_sweep cycle %0d: init_done/req_ready=%b%b, required %b%b",
                 k, init_done, req_ready, k == MD, k == MD);
      end
    end
  endtask

  task automatic test_init_read();
    logic [34:0] got;
    rsp_ready = 1'b1;
    @(negedge clk);
    issue(1'b0, 12'h03C, '0, 4'h0);
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b100, 32'h0}) begin
      n_fail++;
      $display("FAIL init_read_3C: got %h, required %h", got, {3'b100, 32'h0});
    end
  endtask

  task automatic test_byte_enable();
    logic [34:0] got;
    issue(1'b1, 12'h008, 32'hAABBCCDD, 4'b1111);
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b101, 32'h0}) begin
      n_fail++;
      $display("FAIL be_write_full_rsp: got %h, required %h", got, {3'b101, 32'h0});
    end
    issue(1'b1, 12'h008, 32'h11223344, 4'b0101);
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b101, 32'h0}) begin
      n_fail++;
      $display("FAIL be_write_partial_rsp: got %h, required %h", got, {3'b101, 32'h0});
    end
    issue(1'b0, 12'h008, '0, 4'h0);
    @(negedge clk);   // first falling edge after acceptance: latency 1
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b100, 32'hAA22CC44}) begin
      n_fail++;
      $display("FAIL be_readback: got %h, required %h", got, {3'b100, 32'hAA22CC44});
    end
  endtask

  task automatic test_errors();
    logic [34:0] got;
    issue(1'b0, 12'h009, '0, 4'h0);
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b110, 32'h0}) begin
      n_fail++;
      $display("FAIL err_misaligned_read: got %h, required %h", got, {3'b110, 32'h0});
    end
    // Word 16 would alias word 0 if the range check were missing
    issue(1'b1, 12'h040, 32'hDEADBEEF, 4'b1111);
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b111, 32'h0}) begin
      n_fail++;
      $display("FAIL err_range_write: got %h, required %h", got, {3'b111, 32'h0});
    end
    issue(1'b0, 12'h000, '0, 4'h0);
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b100, 32'h0}) begin
      n_fail++;
      $display("FAIL err_word0_untouched: got %h, required %h", got, {3'b100, 32'h0});
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] got;
    issue(1'b1, 12'h004, 32'h01010101, 4'hF);
    issue(1'b1, 12'h00C, 32'h03030303, 4'hF);
    issue(1'b1, 12'h008, 32'h02020202, 4'hF);
    @(negedge clk);
    @(negedge clk);   // buffer drained
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h004;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_ready: got %b, required 1", req_ready);
    end
    @(posedge clk); #1 req_addr = 12'h008;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second_ready: got %b, required 1", req_ready);
    end
    @(posedge clk); #1 req_addr = 12'h00C;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
      n_cmp++;
      if ({req_ready, got} !== {1'b0, 3'b100, 32'h01010101}) begin
        n_fail++;
        $display("FAIL bp_stall cycle %0d: req_ready=%b rsp=%h, required 0 %h",
                 k, req_ready, got, {3'b100, 32'h01010101});
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_on_pop: got %b, required 1", req_ready);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b100, 32'h02020202}) begin
      n_fail++;
      $display("FAIL bp_order_2: got %h, required %h", got, {3'b100, 32'h02020202});
    end
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b100, 32'h03030303}) begin
      n_fail++;
      $display("FAIL bp_order_3: got %h, required %h", got, {3'b100, 32'h03030303});
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] got;
    logic [34:0] exp;
    for (int i = 0; i < 8; i++)
      stream_data[i] = {8'h5A, 8'(i), 8'hA5, 8'(~i)};
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_we    = (i < 8);
      req_addr  = 12'h010 + 12'(4 * (i % 8));
      req_wdata = stream_data[i % 8];
      req_be    = 4'hF;
      #1;
      n_cmp++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_stall op %0d: req_ready=%b, required 1", i, req_ready);
      end
      if (i > 0) begin
        exp = (i - 1 < 8) ? {3'b101, 32'h0} : {3'b100, stream_data[(i - 1) % 8]};
        got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
        n_cmp++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL stream_rsp op %0d: got %h, required %h", i - 1, got, exp);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0; req_we = 1'b0;
    #1;
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b100, stream_data[7]}) begin
      n_fail++;
      $display("FAIL stream_rsp op 15: got %h, required %h", got, {3'b100, stream_data[7]});
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drained: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [34:0] got;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010;
    @(posedge clk); #1 req_addr = 12'h014;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b100, stream_data[0]}) begin
      n_fail++;
      $display("FAIL mid_buffered: got %h, required %h", got, {3'b100, stream_data[0]});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_valid, req_ready, init_done, rsp_rdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL mid_async_clear: valid/ready/done=%b%b%b rdata=%h, required 000 0",
               rsp_valid, req_ready, init_done, rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 1; k <= MD; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({init_done, rsp_valid} !== {k == MD, 1'b0}) begin
        n_fail++;
        $display("FAIL mid_resweep cycle %0d: init_done/rsp_valid=%b%b, required %b0",
                 k, init_done, rsp_valid, k == MD);
      end
    end
    @(negedge clk);
    issue(1'b0, 12'h010, '0, 4'h0);
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b100, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_old_data_cleared_10: got %h, required %h", got, {3'b100, 32'h0});
    end
    issue(1'b0, 12'h008, '0, 4'h0);
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_we, rsp_rdata};
    n_cmp++;
    if (got !== {3'b100, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_old_data_cleared_08: got %h, required %h", got, {3'b100, 32'h0});
    end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_mem_hs
`default_nettype wire
